// File: rtl/bus_master_6502.sv
// Single-initiator peripheral bus engine: serialises write, read and poll commands
// onto the 8-bit peripheral bus, one access at a time, and returns one response per command.
module bus_master_6502 #(
   parameter int                         address_width = 16,
   parameter int                         data_width    = 8,
   parameter int                         ReadLatency   = 1,
   parameter logic [address_width-1:0]   IdleAddress   = {address_width{1'b1}},
   parameter int                         PollTimeout   = 1000,
   parameter int                         PollInterval  = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [1:0]               cmd_op_i,
   input  logic [address_width-1:0] cmd_address_i,
   input  logic [data_width-1:0]    cmd_data_i,
   output logic                     rsp_valid_o,
   output logic [data_width-1:0]    rsp_data_o,
   output logic                     rsp_timeout_o,
   output logic [address_width-1:0] address_o,
   output logic [data_width-1:0]    data_o,
   output logic                     rd_wr_o,
   input  logic [data_width-1:0]    data_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_RD_ADDR,
      S_RD_WAIT,
      S_POLL_GAP,
      S_RESP
   } state_t;

   localparam logic [15:0] WaitInit = 16'((ReadLatency > 0) ? ReadLatency - 1 : 0);
   localparam logic [15:0] GapInit  = 16'((PollInterval > 0) ? PollInterval - 1 : 0);
   localparam logic [15:0] PollMax  = 16'(PollTimeout);

   state_t                     state_q;
   logic [address_width-1:0]   cmd_addr_q;
   logic [data_width-1:0]      cmd_data_q;
   logic                       is_poll_q;
   logic [15:0]                cnt_q;
   logic [15:0]                attempt_q;
   logic                       ready_q;
   logic                       rsp_valid_q;
   logic [data_width-1:0]      rsp_data_q;
   logic                       rsp_timeout_q;
   logic [address_width-1:0]   address_q;
   logic [data_width-1:0]      data_q;
   logic                       rd_wr_q;

   logic [15:0]                attempt_d;
   logic                       poll_hit_d;
   logic                       poll_expired_d;

   assign attempt_d      = attempt_q + 16'd1;
   assign poll_hit_d     = |(data_i & cmd_data_q);
   assign poll_expired_d = (PollTimeout != 0) && (attempt_d == PollMax);

   // Ready is held off while reset is asserted so no command can slip in during reset.
   assign cmd_ready_o   = ready_q & ~reset_i;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_data_o    = rsp_data_q;
   assign rsp_timeout_o = rsp_timeout_q;
   assign address_o     = address_q;
   assign data_o        = data_q;
   assign rd_wr_o       = rd_wr_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         cmd_addr_q    <= '0;
         cmd_data_q    <= '0;
         is_poll_q     <= 1'b0;
         cnt_q         <= '0;
         attempt_q     <= '0;
         ready_q       <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_timeout_q <= 1'b0;
         address_q     <= IdleAddress;
         data_q        <= '0;
         rd_wr_q       <= 1'b0;
      end else begin
         // Bus outputs fall back to idle unless the next state is an access cycle.
         rsp_valid_q <= 1'b0;
         address_q   <= IdleAddress;
         data_q      <= '0;
         rd_wr_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid_i && ready_q) begin
                  cmd_addr_q    <= cmd_address_i;
                  cmd_data_q    <= cmd_data_i;
                  is_poll_q     <= (cmd_op_i == 2'b10);
                  attempt_q     <= '0;
                  rsp_timeout_q <= 1'b0;
                  ready_q       <= 1'b0;
                  address_q     <= cmd_address_i;
                  if (cmd_op_i == 2'b00) begin
                     state_q <= S_WRITE;
                     data_q  <= cmd_data_i;
                     rd_wr_q <= 1'b1;
                  end else begin
                     state_q <= S_RD_ADDR;
                  end
               end
            end
            S_WRITE: begin
               state_q     <= S_RESP;
               rsp_valid_q <= 1'b1;
               rsp_data_q  <= '0;
            end
            S_RD_ADDR: begin
               state_q <= S_RD_WAIT;
               cnt_q   <= WaitInit;
            end
            S_RD_WAIT: begin
               if (cnt_q != 16'd0) begin
                  cnt_q <= cnt_q - 16'd1;
               end else if (!is_poll_q) begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= data_i;
               end else begin
                  attempt_q <= attempt_d;
                  if (poll_hit_d || poll_expired_d) begin
                     state_q       <= S_RESP;
                     rsp_valid_q   <= 1'b1;
                     rsp_data_q    <= data_i;
                     rsp_timeout_q <= ~poll_hit_d;
                  end else if (PollInterval == 0) begin
                     state_q   <= S_RD_ADDR;
                     address_q <= cmd_addr_q;
                  end else begin
                     state_q <= S_POLL_GAP;
                     cnt_q   <= GapInit;
                  end
               end
            end
            S_POLL_GAP: begin
               if (cnt_q != 16'd0) begin
                  cnt_q <= cnt_q - 16'd1;
               end else begin
                  state_q   <= S_RD_ADDR;
                  address_q <= cmd_addr_q;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master_6502.sv
// Bench for bus_master_6502: a byte-memory and timer responder on the bus, and a response
// scoreboard that is filled when each command is sent and drained as responses appear.
module tb_bus_master_6502;

   localparam logic [15:0] IDLE_ADDR = 16'hFFFF;
   localparam logic [15:0] TBASE     = 16'hA000;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [1:0]  cmd_op_i = 2'b00;
   logic [15:0] cmd_address_i = 16'h0000;
   logic [7:0]  cmd_data_i = 8'h00;
   logic        rsp_valid_o;
   logic [7:0]  rsp_data_o;
   logic        rsp_timeout_o;
   logic [15:0] address_o;
   logic [7:0]  data_o;
   logic        rd_wr_o;
   logic [7:0]  data_i;

   bus_master_6502 #(
      .address_width(16),
      .data_width   (8),
      .ReadLatency  (1),
      .IdleAddress  (IDLE_ADDR),
      .PollTimeout  (3),
      .PollInterval (4)
   ) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_op_i     (cmd_op_i),
      .cmd_address_i(cmd_address_i),
      .cmd_data_i   (cmd_data_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_data_o   (rsp_data_o),
      .rsp_timeout_o(rsp_timeout_o),
      .address_o    (address_o),
      .data_o       (data_o),
      .rd_wr_o      (rd_wr_o),
      .data_i       (data_i)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Responder: 256-byte memory at 0x90xx, timer at TBASE (+0 load shift, +1 start, +2 status, read-to-clear).
   logic [7:0]  mem [256];
   bit          mem_init_done = 1'b0;
   logic [7:0]  resp_rdata = 8'h00;
   logic [31:0] tmr_load = 32'h0;
   logic [31:0] tmr_cnt = 32'h0;
   logic        tmr_run = 1'b0;
   logic [7:0]  tmr_status = 8'h00;

   assign data_i = resp_rdata;

   always @(posedge clk_i) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[2] <= 8'hC3;
         mem_init_done <= 1'b1;
      end else if (rd_wr_o && address_o[15:8] == 8'h90) begin
         mem[address_o[7:0]] <= data_o;
      end
      if (address_o[15:8] == 8'h90) resp_rdata <= mem[address_o[7:0]];
      else if (address_o == TBASE + 16'd2) resp_rdata <= tmr_status;
      else resp_rdata <= 8'h00;
      if (rd_wr_o && address_o == TBASE) tmr_load <= {tmr_load[23:0], data_o};
      if (rd_wr_o && address_o == TBASE + 16'd1) begin
         tmr_cnt <= tmr_load;
         tmr_run <= 1'b1;
      end else if (tmr_run) begin
         if (tmr_cnt <= 32'd1) begin
            tmr_status <= 8'h01;
            tmr_run    <= 1'b0;
         end else begin
            tmr_cnt <= tmr_cnt - 32'd1;
         end
      end else if (!rd_wr_o && address_o == TBASE + 16'd2) begin
         tmr_status <= 8'h00;
      end
   end

   typedef struct {
      int         cyc;
      logic [15:0] addr;
      logic [7:0]  data;
   } bus_ev_t;

   typedef struct {
      logic [7:0] data;
      logic       to;
      int         cyc;
   } exp_t;

   bus_ev_t rd_log[$];
   bus_ev_t wr_log[$];
   exp_t    exp_q[$];

   // Monitor: logs bus accesses and scores responses, sampled on the falling edge.
   always @(negedge clk_i) begin
      if (!reset_i) begin
         if (address_o != IDLE_ADDR) begin
            bus_ev_t ev;
            ev.cyc  = cyc;
            ev.addr = address_o;
            ev.data = data_o;
            if (rd_wr_o) wr_log.push_back(ev);
            else rd_log.push_back(ev);
            if (cmd_ready_o) check("ready_during_access", 32'(cmd_ready_o), 32'd0);
         end else if (rd_wr_o || data_o != 8'h00) begin
            check("idle_bus_quiet", {23'd0, rd_wr_o, data_o}, 32'd0);
         end
         if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("rsp_data", 32'(rsp_data_o), 32'(e.data));
               check("rsp_timeout", 32'(rsp_timeout_o), 32'(e.to));
               if (e.cyc >= 0) check("rsp_cycle", 32'(cyc), 32'(e.cyc));
               $display("rsp: data=0x%02h timeout=%0d cycle=%0d", rsp_data_o, rsp_timeout_o, cyc);
            end
         end
      end
   end

   // Call at a falling edge; returns handshake cycle t and leaves the caller at cycle t+1.
   task automatic send(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] d,
                       input bit push, input logic [7:0] exp_data, input logic exp_to,
                       input int exp_dcyc, output int t);
      int n;
      exp_t e;
      n = 0;
      cmd_valid_i   = 1'b1;
      cmd_op_i      = op;
      cmd_address_i = addr;
      cmd_data_i    = d;
      while (!cmd_ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 200) check("handshake_wait", 32'(n), 32'd0);
      t = cyc;
      $display("cmd: op=%0d addr=0x%04h data=0x%02h handshake cycle=%0d", op, addr, d, t);
      if (push) begin
         e.data = exp_data;
         e.to   = exp_to;
         e.cyc  = (exp_dcyc >= 0) ? t + exp_dcyc : -1;
         exp_q.push_back(e);
      end
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 300) check("rsp_wait", 32'(exp_q.size()), 32'd0);
      @(negedge clk_i);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, t0, t1, t2;

      repeat (3) @(negedge clk_i);
      check("rst_ready", 32'(cmd_ready_o), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_rsp_data", 32'(rsp_data_o), 32'd0);
      check("rst_rsp_timeout", 32'(rsp_timeout_o), 32'd0);
      check("rst_address", 32'(address_o), 32'(IDLE_ADDR));
      check("rst_data", 32'(data_o), 32'd0);
      check("rst_rd_wr", 32'(rd_wr_o), 32'd0);
      reset_i = 1'b0;
      @(negedge clk_i);
      check("ready_after_rst", 32'(cmd_ready_o), 32'd1);

      // Single write: one bus cycle at T+1, response at T+2 with zero data.
      rd_log.delete();
      wr_log.delete();
      send(2'b00, 16'h9000, 8'h5A, 1'b1, 8'h00, 1'b0, 2, t);
      wait_done();
      check("wr_count", 32'(wr_log.size()), 32'd1);
      check("wr_rd_count", 32'(rd_log.size()), 32'd0);
      if (wr_log.size() > 0) begin
         check("wr_cycle", 32'(wr_log[0].cyc - t), 32'd1);
         check("wr_addr", 32'(wr_log[0].addr), 32'h9000);
         check("wr_data", 32'(wr_log[0].data), 32'h5A);
      end

      // Single read: address for exactly one cycle, response at T+3.
      rd_log.delete();
      send(2'b01, 16'h9002, 8'h00, 1'b1, 8'hC3, 1'b0, 3, t);
      wait_done();
      check("rd_count", 32'(rd_log.size()), 32'd1);
      if (rd_log.size() > 0) begin
         check("rd_cycle", 32'(rd_log[0].cyc - t), 32'd1);
         check("rd_addr", 32'(rd_log[0].addr), 32'h9002);
      end

      // Timer: load 0x0000000A, start, poll status bit 0, then confirm read-to-clear.
      send(2'b00, TBASE, 8'h00, 1'b1, 8'h00, 1'b0, 2, t);
      send(2'b00, TBASE, 8'h00, 1'b1, 8'h00, 1'b0, 2, t);
      send(2'b00, TBASE, 8'h00, 1'b1, 8'h00, 1'b0, 2, t);
      send(2'b00, TBASE, 8'h0A, 1'b1, 8'h00, 1'b0, 2, t);
      send(2'b00, TBASE + 16'd1, 8'h00, 1'b1, 8'h00, 1'b0, 2, t);
      send(2'b10, TBASE + 16'd2, 8'h01, 1'b1, 8'h01, 1'b0, -1, t);
      wait_done();
      send(2'b01, TBASE + 16'd2, 8'h00, 1'b1, 8'h00, 1'b0, 3, t);
      wait_done();

      // Poll that never matches: three reads spaced 6 cycles, then timeout.
      rd_log.delete();
      send(2'b10, 16'h9010, 8'hFF, 1'b1, 8'h00, 1'b1, 15, t);
      wait_done();
      check("to_reads", 32'(rd_log.size()), 32'd3);
      if (rd_log.size() == 3) begin
         check("to_first", 32'(rd_log[0].cyc - t), 32'd1);
         check("to_gap1", 32'(rd_log[1].cyc - rd_log[0].cyc), 32'd6);
         check("to_gap2", 32'(rd_log[2].cyc - rd_log[1].cyc), 32'd6);
      end

      // Mask 0 never matches even on non-zero data.
      rd_log.delete();
      send(2'b10, 16'h9002, 8'h00, 1'b1, 8'hC3, 1'b1, 15, t);
      wait_done();
      check("mask0_reads", 32'(rd_log.size()), 32'd3);

      // Reset during the poll gap: no response, idle bus, ready right after release.
      send(2'b10, 16'h9010, 8'h01, 1'b0, 8'h00, 1'b0, -1, t);
      repeat (3) @(negedge clk_i);
      reset_i = 1'b1;
      @(negedge clk_i);
      check("midrst_ready", 32'(cmd_ready_o), 32'd0);
      check("midrst_addr", 32'(address_o), 32'(IDLE_ADDR));
      check("midrst_rsp", 32'(rsp_valid_o), 32'd0);
      reset_i = 1'b0;
      rd_log.delete();
      @(negedge clk_i);
      check("postrst_ready", 32'(cmd_ready_o), 32'd1);
      check("postrst_addr", 32'(address_o), 32'(IDLE_ADDR));
      repeat (25) @(negedge clk_i);
      check("postrst_reads", 32'(rd_log.size()), 32'd0);
      send(2'b01, 16'h9002, 8'h00, 1'b1, 8'hC3, 1'b0, 3, t);
      wait_done();

      // Three queued commands with valid held: strictly serialised, in order.
      send(2'b00, 16'h9005, 8'h77, 1'b1, 8'h00, 1'b0, 2, t0);
      send(2'b01, 16'h9005, 8'h00, 1'b1, 8'h77, 1'b0, 3, t1);
      send(2'b11, 16'h9002, 8'h00, 1'b1, 8'hC3, 1'b0, 3, t2);
      wait_done();
      check("bp_spacing_wr", 32'(t1 - t0), 32'd3);
      check("bp_spacing_rd", 32'(t2 - t1), 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
